// File: rtl/pic_nest_ctrl.sv
// ---------------------------------------------------------------------------
// pic_nest_ctrl
// Nesting controller for a priority interrupt controller. A resolver upstream
// reports the highest-priority unmasked request (req_i / irq_no_i). This block
// raises int_o toward the CPU when that request outranks the line currently in
// service, and on inta_i it hands out the vector and pushes the line onto an
// in-service stack. eoi_i pops the stack.
//
// Optional feature macro: PIC_AUTO_EOI_EN
//   When defined, acknowledges do not push, nothing is ever in service, and
//   eoi_i is ignored. The controller then only moves between IDLE and REQ.
//
// Parameters:
//   SPUR_VEC     vector returned on a spurious acknowledge
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_i        at least one unmasked request line active
//   irq_no_i     highest-priority active line (0 = highest, 7 = lowest)
//   inta_i       CPU interrupt acknowledge (one-cycle pulse)
//   eoi_i        CPU end of interrupt (one-cycle pulse)
//   int_o        interrupt request to CPU (registered)
//   vec_o        acknowledged line number, valid with vec_valid_o
//   vec_valid_o  one-cycle pulse, the cycle after inta_i
//   isr_o        in-service mask, bit n = line n in service
//   pri_o        service level of the stack top (7 - irq_no), 0 when idle
//   busy_o       at least one line in service
//   spur_o       one-cycle pulse on a spurious acknowledge
//   err_o        one-cycle pulse on EOI with an empty stack
// ---------------------------------------------------------------------------
module pic_nest_ctrl #(
    parameter logic [2:0] SPUR_VEC = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic [2:0] irq_no_i,
    input  logic       inta_i,
    input  logic       eoi_i,
    output logic       int_o,
    output logic [2:0] vec_o,
    output logic       vec_valid_o,
    output logic [7:0] isr_o,
    output logic [2:0] pri_o,
    output logic       busy_o,
    output logic       spur_o,
    output logic       err_o
);

`ifdef PIC_AUTO_EOI_EN
    localparam logic AUTO_EOI = 1'b1;
`else
    localparam logic AUTO_EOI = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;

    logic [2:0] stack_r     [8];
    logic [2:0] stack_nxt_s [8];
    logic [3:0] depth_r;
    logic [3:0] depth_nxt_s;

    logic       int_r;
    logic [2:0] vec_r;
    logic       vec_valid_r;
    logic [7:0] isr_r;
    logic [2:0] pri_r;
    logic       busy_r;
    logic       spur_r;
    logic       err_r;

    logic       int_nxt_s;
    logic [2:0] vec_nxt_s;
    logic       vec_valid_nxt_s;
    logic [7:0] isr_nxt_s;
    logic [2:0] pri_nxt_s;
    logic       busy_nxt_s;
    logic       spur_nxt_s;
    logic       err_nxt_s;

    logic [2:0] level_s;
    logic       qualify_s;
    logic       ack_s;
    logic       push_s;
    logic       pop_s;
    logic [2:0] top_idx_s;
    logic [2:0] new_top_idx_s;

    // Request qualification and acknowledge/EOI decode against current state.
    always_comb begin
        level_s   = 3'd7 - irq_no_i;
        qualify_s = req_i && (!busy_r || (level_s > pri_r));
        ack_s     = inta_i && int_r;
        push_s    = ack_s && !AUTO_EOI;
        pop_s     = eoi_i && busy_r && !AUTO_EOI;
        // Wraps to 7 for depth 8 and is unused for depth 0.
        top_idx_s = depth_r[2:0] - 3'd1;
    end

    // In-service stack update; push+pop in one cycle replaces the top entry.
    always_comb begin
        stack_nxt_s = stack_r;
        depth_nxt_s = depth_r;
        isr_nxt_s   = isr_r;
        if (push_s && pop_s) begin
            stack_nxt_s[top_idx_s] = irq_no_i;
            isr_nxt_s = (isr_r & ~(8'd1 << stack_r[top_idx_s])) | (8'd1 << irq_no_i);
        end else if (push_s) begin
            if (depth_r < 4'd8) begin
                stack_nxt_s[depth_r[2:0]] = irq_no_i;
                depth_nxt_s = depth_r + 4'd1;
                isr_nxt_s   = isr_r | (8'd1 << irq_no_i);
            end else begin
                depth_nxt_s = depth_r;
            end
        end else if (pop_s) begin
            depth_nxt_s = depth_r - 4'd1;
            isr_nxt_s   = isr_r & ~(8'd1 << stack_r[top_idx_s]);
        end else begin
            depth_nxt_s = depth_r;
        end
    end

    // Service level and busy flag follow the post-update stack top.
    always_comb begin
        new_top_idx_s = depth_nxt_s[2:0] - 3'd1;
        busy_nxt_s    = (depth_nxt_s != 4'd0);
        if (busy_nxt_s) begin
            pri_nxt_s = 3'd7 - stack_nxt_s[new_top_idx_s];
        end else begin
            pri_nxt_s = 3'd0;
        end
    end

    // FSM next-state: raise on qualification, settle to SVC/IDLE by stack depth.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (qualify_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_nxt_s = busy_nxt_s ? ST_SVC : ST_IDLE;
                end else if (qualify_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = busy_nxt_s ? ST_SVC : ST_IDLE;
                end
            end
            ST_SVC: begin
                if (qualify_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = busy_nxt_s ? ST_SVC : ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: int request level plus acknowledge/error pulses.
    always_comb begin
        int_nxt_s       = (state_nxt_s == ST_REQ);
        vec_valid_nxt_s = inta_i;
        spur_nxt_s      = inta_i && !int_r;
        err_nxt_s       = eoi_i && !busy_r && !AUTO_EOI;
        if (ack_s) begin
            vec_nxt_s = irq_no_i;
        end else if (inta_i) begin
            vec_nxt_s = SPUR_VEC;
        end else begin
            vec_nxt_s = vec_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stack storage and depth counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_r <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                stack_r[i] <= 3'd0;
            end
        end else begin
            depth_r <= depth_nxt_s;
            stack_r <= stack_nxt_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_r       <= 1'b0;
            vec_r       <= 3'd0;
            vec_valid_r <= 1'b0;
            isr_r       <= 8'd0;
            pri_r       <= 3'd0;
            busy_r      <= 1'b0;
            spur_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            int_r       <= int_nxt_s;
            vec_r       <= vec_nxt_s;
            vec_valid_r <= vec_valid_nxt_s;
            isr_r       <= isr_nxt_s;
            pri_r       <= pri_nxt_s;
            busy_r      <= busy_nxt_s;
            spur_r      <= spur_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    assign int_o       = int_r;
    assign vec_o       = vec_r;
    assign vec_valid_o = vec_valid_r;
    assign isr_o       = isr_r;
    assign pri_o       = pri_r;
    assign busy_o      = busy_r;
    assign spur_o      = spur_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_pic_nest_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pic_nest_ctrl
// Self-checking bench for pic_nest_ctrl: directed scenarios followed by
// random stimulus, all outputs compared every cycle against a queue-based
// behavioural model of the nesting rules.
// ---------------------------------------------------------------------------
module tb_pic_nest_ctrl;

`ifdef PIC_AUTO_EOI_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       req_i;
    logic [2:0] irq_no_i;
    logic       inta_i;
    logic       eoi_i;
    logic       int_o;
    logic [2:0] vec_o;
    logic       vec_valid_o;
    logic [7:0] isr_o;
    logic [2:0] pri_o;
    logic       busy_o;
    logic       spur_o;
    logic       err_o;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: stack of line numbers, bottom first.
    int       stk[$];
    bit       int_m;
    bit [2:0] vec_m;
    bit       vv_m;
    bit       spur_m;
    bit       err_m;

    pic_nest_ctrl #(.SPUR_VEC(3'd7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .irq_no_i    (irq_no_i),
        .inta_i      (inta_i),
        .eoi_i       (eoi_i),
        .int_o       (int_o),
        .vec_o       (vec_o),
        .vec_valid_o (vec_valid_o),
        .isr_o       (isr_o),
        .pri_o       (pri_o),
        .busy_o      (busy_o),
        .spur_o      (spur_o),
        .err_o       (err_o)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [7:0] model_isr();
        bit [7:0] m = 8'd0;
        foreach (stk[i]) m[stk[i]] = 1'b1;
        return m;
    endfunction

    function automatic int model_pri();
        return (stk.size() == 0) ? 0 : 7 - stk[$];
    endfunction

    function automatic void model_reset();
        stk.delete();
        int_m  = 1'b0;
        vec_m  = 3'd0;
        vv_m   = 1'b0;
        spur_m = 1'b0;
        err_m  = 1'b0;
    endfunction

    // Apply one clock edge of the nesting rules to the model.
    function automatic void model_edge(input bit r, input int irq, input bit ia, input bit eo);
        bit qual;
        bit ack;
        bit pop;
        qual   = r && (stk.size() == 0 || (7 - irq) > model_pri());
        ack    = ia && int_m;
        pop    = !AUTO && eo && stk.size() > 0;
        err_m  = !AUTO && eo && stk.size() == 0;
        vv_m   = ia;
        spur_m = ia && !int_m;
        if (ia) vec_m = ack ? irq[2:0] : 3'd7;
        if (pop) void'(stk.pop_back());
        if (ack && !AUTO) stk.push_back(irq);
        int_m = ack ? 1'b0 : qual;
    endfunction

    task automatic compare_all();
        check("int_o", int_o, int_m);
        check("vec_o", vec_o, vec_m);
        check("vec_valid_o", vec_valid_o, vv_m);
        check("isr_o", isr_o, model_isr());
        check("pri_o", pri_o, model_pri());
        check("busy_o", busy_o, stk.size() != 0);
        check("spur_o", spur_o, spur_m);
        check("err_o", err_o, err_m);
    endtask

    task automatic step(input bit r, input int irq, input bit ia, input bit eo);
        req_i    = r;
        irq_no_i = irq[2:0];
        inta_i   = ia;
        eoi_i    = eo;
        @(posedge clk);
        model_edge(r, irq, ia, eo);
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_int"}, int_o, 0);
        check({tag, "_vec"}, vec_o, 0);
        check({tag, "_vv"}, vec_valid_o, 0);
        check({tag, "_isr"}, isr_o, 0);
        check({tag, "_pri"}, pri_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_spur"}, spur_o, 0);
        check({tag, "_err"}, err_o, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        req_i    = 1'b0;
        irq_no_i = 3'd0;
        inta_i   = 1'b0;
        eoi_i    = 1'b0;
        model_reset();
        #3;
        check_all_zero("reset");
        #9 rst_n = 1'b1;   // release between edges

        // First request on line 5, then acknowledge.
        step(1, 5, 0, 0);
        check("req5_int", int_o, 1);
        step(1, 5, 1, 0);
`ifndef PIC_AUTO_EOI_EN
        check("ack5_vec", vec_o, 5);
        check("ack5_vv", vec_valid_o, 1);
        check("ack5_isr", isr_o, 8'h20);
        check("ack5_pri", pri_o, 2);
`endif
        step(0, 5, 0, 0);

        // Nest line 2 above line 5; line 6 must not interrupt; two EOIs.
        step(1, 2, 0, 0);
        step(1, 2, 1, 0);
`ifndef PIC_AUTO_EOI_EN
        check("nest2_isr", isr_o, 8'h24);
        check("nest2_pri", pri_o, 5);
`endif
        step(1, 6, 0, 0);
        step(1, 6, 0, 0);
`ifndef PIC_AUTO_EOI_EN
        check("low6_int", int_o, 0);
`endif
        step(0, 0, 0, 1);
`ifndef PIC_AUTO_EOI_EN
        check("eoi1_isr", isr_o, 8'h20);
        check("eoi1_pri", pri_o, 2);
`endif
        step(0, 0, 0, 1);
        check("eoi2_isr", isr_o, 8'h00);
        check("eoi2_pri", pri_o, 0);

        // Spurious acknowledge.
        step(0, 0, 1, 0);
        check("spur_vec", vec_o, 7);
        check("spur_pulse", spur_o, 1);
        check("spur_isr", isr_o, 8'h00);

        // EOI while idle, then same-cycle acknowledge + EOI.
        step(0, 0, 0, 1);
`ifndef PIC_AUTO_EOI_EN
        check("idle_eoi_err", err_o, 1);
`endif
        step(1, 4, 0, 0);
        step(1, 4, 1, 0);
`ifndef PIC_AUTO_EOI_EN
        check("ack4_isr", isr_o, 8'h10);
`endif
        step(1, 1, 0, 0);
        check("req1_int", int_o, 1);
        step(1, 1, 1, 1);
`ifndef PIC_AUTO_EOI_EN
        check("swap_isr", isr_o, 8'h02);
        check("swap_pri", pri_o, 6);
        check("swap_busy", busy_o, 1);
`endif
        step(0, 0, 0, 1);

        // Build depth 3, then reset asynchronously between edges.
        step(1, 5, 0, 0);
        step(1, 5, 1, 0);
        step(1, 2, 0, 0);
        step(1, 2, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
`ifndef PIC_AUTO_EOI_EN
        check("depth3_isr", isr_o, 8'h25);
`endif
        step(1, 3, 1, 0);   // spurious: vec_o becomes 7 so reset is visible
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        #3 rst_n = 1'b1;
        step(1, 6, 0, 0);
        check("post_rst_int", int_o, 1);
        step(0, 6, 0, 0);

`ifdef PIC_AUTO_EOI_EN
        // Auto-EOI: acknowledge hands out the vector but nothing goes in service.
        step(1, 3, 0, 0);
        step(1, 3, 1, 0);
        check("auto_vec", vec_o, 3);
        check("auto_isr", isr_o, 8'h00);
        step(0, 0, 0, 1);
        check("auto_err", err_o, 0);
`endif

        // Random phase.
        for (int n = 0; n < 1500; n++) begin
            bit r  = ($urandom_range(0, 3) != 0);
            int q  = $urandom_range(0, 7);
            bit ia = ($urandom_range(0, 3) == 0);
            bit eo = ($urandom_range(0, 5) == 0);
            // A real acknowledge only follows a still-qualifying request.
            if (ia && int_m) begin
                if (stk.size() == 0) begin
                    r = 1'b1;
                end else if (stk[$] > 0) begin
                    r = 1'b1;
                    q = $urandom_range(0, stk[$] - 1);
                end else begin
                    ia = 1'b0;
                end
            end
            step(r, q, ia, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
